// File: rtl/pixel_channel_serializer_if.sv
// rtl/pixel_channel_serializer_if.sv - pixel-in / channel-beat-out bus bundle
interface pixel_channel_serializer_if #(
   parameter int W   = 8,
   parameter int NCH = 3
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH*W-1:0] pix_data;
   logic             pix_valid;
   logic             pix_ready;
   logic [NCH-1:0]   chan_mask;
   logic [W-1:0]     out_data;
   logic [CW-1:0]    out_chan;
   logic             out_last;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      drop_cnt;

   // Environment side: offers pixels, accepts beats.
   modport master (
      output pix_data, pix_valid, chan_mask, out_ready,
      input  pix_ready, out_data, out_chan, out_last, out_valid, drop_cnt
   );

   // Serializer side.
   modport slave (
      input  pix_data, pix_valid, chan_mask, out_ready,
      output pix_ready, out_data, out_chan, out_last, out_valid, drop_cnt
   );
endinterface

// File: rtl/pixel_channel_serializer.sv
// rtl/pixel_channel_serializer.sv - splits a packed pixel into masked per-channel beats
module pixel_channel_serializer #(
   parameter int W        = 8,
   parameter int NCH      = 3,
   parameter int CH_ORDER = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   pixel_channel_serializer_if.slave   bus
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state;
   logic [NCH*W-1:0] pix_q;
   logic [NCH-1:0]   rem_q;      // enabled channels not yet presented
   logic [W-1:0]     out_data_q;
   logic [CW-1:0]    out_chan_q;
   logic             out_last_q;
   logic             out_valid_q;
   logic [15:0]      drop_q;

   logic             pix_ready;
   logic             accept;
   logic [W-1:0]     ch_new [NCH];
   logic [W-1:0]     ch_held [NCH];
   logic [CW-1:0]    new_idx, rem_idx;
   logic [NCH-1:0]   new_rest, rem_rest;

   // First enabled channel of a mask in the configured transmit order.
   function automatic logic [CW-1:0] pick(input logic [NCH-1:0] m);
      logic [CW-1:0] idx;
      idx = '0;
      if (CH_ORDER == 0) begin
         for (int k = NCH - 1; k >= 0; k--)
            if (m[k]) idx = CW'(k);
      end else begin
         for (int k = 0; k < NCH; k++)
            if (m[k]) idx = CW'(k);
      end
      return idx;
   endfunction

   // A new pixel fits when idle, or when the final beat of the current one leaves now.
   assign pix_ready = ~rst & ((state == IDLE) | (out_valid_q & bus.out_ready & out_last_q));
   assign accept    = bus.pix_valid & pix_ready;

   // Unpack incoming and latched pixels, and find the next channel for each source.
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         ch_new[k]  = bus.pix_data[k*W +: W];
         ch_held[k] = pix_q[k*W +: W];
      end
      new_idx  = pick(bus.chan_mask);
      rem_idx  = pick(rem_q);
      new_rest = bus.chan_mask & ~(NCH'(1) << new_idx);
      rem_rest = rem_q & ~(NCH'(1) << rem_idx);
   end

   // IDLE/SEND sequencing with registered beat outputs and the drop counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pix_q       <= '0;
         rem_q       <= '0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         drop_q      <= '0;
      end else if (accept) begin
         pix_q <= bus.pix_data;
         if (|bus.chan_mask) begin
            state       <= SEND;
            out_valid_q <= 1'b1;
            out_chan_q  <= new_idx;
            out_data_q  <= ch_new[new_idx];
            out_last_q  <= (new_rest == '0);
            rem_q       <= new_rest;
         end else begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            rem_q       <= '0;
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
         end
      end else if (state == SEND && bus.out_ready) begin
         if (out_last_q) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
         end else begin
            out_chan_q <= rem_idx;
            out_data_q <= ch_held[rem_idx];
            out_last_q <= (rem_rest == '0);
            rem_q      <= rem_rest;
         end
      end
   end

   assign bus.pix_ready = pix_ready;
   assign bus.out_data  = out_data_q;
   assign bus.out_chan  = out_chan_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_valid = out_valid_q;
   assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_pixel_channel_serializer.sv
// tb/tb_pixel_channel_serializer.sv - self-checking bench for pixel_channel_serializer
module tb_pixel_channel_serializer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Three builds: default, descending order, and 4x16-bit.
   localparam int NI = 3;
   int cfg_w   [NI] = '{8, 8, 16};
   int cfg_n   [NI] = '{3, 3, 4};
   int cfg_ord [NI] = '{0, 1, 0};

   logic [63:0] pd   [NI];
   logic [3:0]  pm   [NI];
   logic        pv   [NI];
   logic        ordy [NI];
   logic        ov   [NI];
   logic        ol   [NI];
   logic        pr   [NI];
   logic [15:0] od   [NI];
   logic [1:0]  oc   [NI];
   logic [15:0] dc   [NI];

   pixel_channel_serializer_if #(.W(8),  .NCH(3)) if0 ();
   pixel_channel_serializer_if #(.W(8),  .NCH(3)) if1 ();
   pixel_channel_serializer_if #(.W(16), .NCH(4)) if2 ();

   pixel_channel_serializer #(.W(8),  .NCH(3), .CH_ORDER(0)) d0 (.clk(clk), .rst(rst), .bus(if0));
   pixel_channel_serializer #(.W(8),  .NCH(3), .CH_ORDER(1)) d1 (.clk(clk), .rst(rst), .bus(if1));
   pixel_channel_serializer #(.W(16), .NCH(4), .CH_ORDER(0)) d2 (.clk(clk), .rst(rst), .bus(if2));

   assign if0.pix_data = pd[0][23:0];  assign if0.chan_mask = pm[0][2:0];
   assign if0.pix_valid = pv[0];       assign if0.out_ready = ordy[0];
   assign if1.pix_data = pd[1][23:0];  assign if1.chan_mask = pm[1][2:0];
   assign if1.pix_valid = pv[1];       assign if1.out_ready = ordy[1];
   assign if2.pix_data = pd[2];        assign if2.chan_mask = pm[2];
   assign if2.pix_valid = pv[2];       assign if2.out_ready = ordy[2];

   assign ov[0] = if0.out_valid; assign ol[0] = if0.out_last; assign pr[0] = if0.pix_ready;
   assign od[0] = {8'h00, if0.out_data}; assign oc[0] = if0.out_chan; assign dc[0] = if0.drop_cnt;
   assign ov[1] = if1.out_valid; assign ol[1] = if1.out_last; assign pr[1] = if1.pix_ready;
   assign od[1] = {8'h00, if1.out_data}; assign oc[1] = if1.out_chan; assign dc[1] = if1.drop_cnt;
   assign ov[2] = if2.out_valid; assign ol[2] = if2.out_last; assign pr[2] = if2.pix_ready;
   assign od[2] = if2.out_data;          assign oc[2] = if2.out_chan; assign dc[2] = if2.drop_cnt;

   int ncmp = 0;
   int nfail = 0;

   task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, inst, $time, act, exp);
      end
   endtask

   // Model: the pending beats of the pixel in flight, in transmit order.
   logic [15:0] bd [NI][4];
   logic [1:0]  bc [NI][4];
   logic        bl [NI][4];
   int          head [NI];
   int          cnt  [NI];
   int          mdrop [NI];
   logic [15:0] hd [NI];
   logic [1:0]  hc [NI];

   initial begin
      for (int i = 0; i < NI; i++) begin
         head[i] = 0; cnt[i] = 0; mdrop[i] = 0; hd[i] = '0; hc[i] = '0;
         pd[i] = '0; pm[i] = '0; pv[i] = 1'b0; ordy[i] = 1'b1;
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            cnt[i] = 0; head[i] = 0; mdrop[i] = 0; hd[i] = '0; hc[i] = '0;
         end else begin
            logic rdy;
            logic [3:0] m;
            int n;
            rdy = (cnt[i] == 0) || (cnt[i] == 1 && ordy[i]);
            if (cnt[i] > 0 && ordy[i]) begin
               hd[i] = bd[i][head[i]];
               hc[i] = bc[i][head[i]];
               head[i]++;
               cnt[i]--;
            end
            if (pv[i] && rdy) begin
               m = pm[i] & 4'((1 << cfg_n[i]) - 1);
               if (m == 0) begin
                  if (mdrop[i] < 65535) mdrop[i]++;
               end else begin
                  n = 0;
                  for (int j = 0; j < cfg_n[i]; j++) begin
                     int k;
                     k = (cfg_ord[i] != 0) ? cfg_n[i] - 1 - j : j;
                     if (m[k]) begin
                        bd[i][n] = 16'((pd[i] >> (k * cfg_w[i])) & ((64'd1 << cfg_w[i]) - 1));
                        bc[i][n] = 2'(k);
                        bl[i][n] = 1'b0;
                        n++;
                     end
                  end
                  bl[i][n-1] = 1'b1;
                  head[i] = 0;
                  cnt[i] = n;
               end
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         chk("pix_ready", i, 32'(pr[i]), 32'(!rst && (cnt[i] == 0 || (cnt[i] == 1 && ordy[i]))));
         chk("out_valid", i, 32'(ov[i]), 32'(cnt[i] > 0));
         chk("drop_cnt", i, 32'(dc[i]), 32'(mdrop[i]));
         if (cnt[i] > 0) begin
            chk("out_data", i, 32'(od[i]), 32'(bd[i][head[i]]));
            chk("out_chan", i, 32'(oc[i]), 32'(bc[i][head[i]]));
            chk("out_last", i, 32'(ol[i]), 32'(bl[i][head[i]]));
         end else begin
            chk("held_data", i, 32'(od[i]), 32'(hd[i]));
            chk("held_chan", i, 32'(oc[i]), 32'(hc[i]));
         end
      end
   end

   task automatic cyc(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic beat(input string nm, input int i, input logic [15:0] d, input logic [1:0] c, input logic l);
      @(negedge clk);
      chk({nm, "_v"}, i, 32'(ov[i]), 32'd1);
      chk({nm, "_d"}, i, 32'(od[i]), 32'(d));
      chk({nm, "_c"}, i, 32'(oc[i]), 32'(c));
      chk({nm, "_l"}, i, 32'(ol[i]), 32'(l));
   endtask

   logic [7:0] seq6 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

   initial begin
      cyc(3);
      @(negedge clk);
      chk("rst_ready", 0, 32'(pr[0]), 32'd0);
      chk("rst_valid", 0, 32'(ov[0]), 32'd0);
      chk("rst_drop", 0, 32'(dc[0]), 32'd0);
      rst = 1'b0;
      cyc(2);

      // Full mask, ascending.
      pd[0] = 64'h332211; pm[0] = 4'b0111; pv[0] = 1'b1;
      cyc(); pv[0] = 1'b0;
      beat("t1b0", 0, 16'h11, 2'd0, 1'b0); cyc();
      beat("t1b1", 0, 16'h22, 2'd1, 1'b0); cyc();
      beat("t1b2", 0, 16'h33, 2'd2, 1'b1);
      chk("t1_ready_last", 0, 32'(pr[0]), 32'd1);
      cyc();
      @(negedge clk);
      chk("t1_idle_v", 0, 32'(ov[0]), 32'd0);
      chk("t1_hold_d", 0, 32'(od[0]), 32'h33);
      cyc(2);

      // Descending order, channel 1 skipped.
      pd[1] = 64'h332211; pm[1] = 4'b0101; pv[1] = 1'b1;
      cyc(); pv[1] = 1'b0;
      beat("t2b0", 1, 16'h33, 2'd2, 1'b0); cyc();
      beat("t2b1", 1, 16'h11, 2'd0, 1'b1); cyc(3);

      // Back-pressure on beat 2.
      pd[0] = 64'h332211; pm[0] = 4'b0111; pv[0] = 1'b1;
      cyc(); pv[0] = 1'b0;
      cyc(); ordy[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         beat("t3stall", 0, 16'h22, 2'd1, 1'b0);
         chk("t3_ready", 0, 32'(pr[0]), 32'd0);
         cyc();
      end
      ordy[0] = 1'b1;
      beat("t3b1", 0, 16'h22, 2'd1, 1'b0); cyc();
      beat("t3b2", 0, 16'h33, 2'd2, 1'b1); cyc(3);

      // Back-to-back pixels with no bubble.
      pd[0] = 64'h332211; pm[0] = 4'b0111; pv[0] = 1'b1;
      cyc(); pd[0] = 64'h665544;
      for (int k = 0; k < 6; k++) begin
         beat("t4", 0, 16'(seq6[k]), 2'(k % 3), (k % 3) == 2);
         cyc();
         if (k == 2) pv[0] = 1'b0;
      end
      @(negedge clk);
      chk("t4_end_v", 0, 32'(ov[0]), 32'd0);
      cyc(2);

      // Three dropped pixels then a single-channel pixel.
      pm[0] = 4'b0000; pv[0] = 1'b1;
      cyc(3);
      pm[0] = 4'b0010; pd[0] = 64'h665544;
      cyc(); pv[0] = 1'b0;
      beat("t5b", 0, 16'h55, 2'd1, 1'b1);
      chk("t5_drop", 0, 32'(dc[0]), 32'd3);
      cyc();
      @(negedge clk);
      chk("t5_idle_v", 0, 32'(ov[0]), 32'd0);
      chk("t5_hold_d", 0, 32'(od[0]), 32'h55);
      cyc(2);

      // Reset pulse in the middle of a pixel.
      pd[0] = 64'h332211; pm[0] = 4'b0111; pv[0] = 1'b1;
      cyc(); pv[0] = 1'b0;
      cyc(); rst = 1'b1;
      cyc(); rst = 1'b0;
      @(negedge clk);
      chk("t6_v", 0, 32'(ov[0]), 32'd0);
      chk("t6_d", 0, 32'(od[0]), 32'd0);
      chk("t6_drop", 0, 32'(dc[0]), 32'd0);
      pd[0] = 64'h665544; pm[0] = 4'b0111; pv[0] = 1'b1;
      cyc(); pv[0] = 1'b0;
      beat("t6b0", 0, 16'h44, 2'd0, 1'b0); cyc(4);

      // Four 16-bit channels.
      pd[2] = 64'h4444_3333_2222_1111; pm[2] = 4'b1111; pv[2] = 1'b1;
      cyc(); pv[2] = 1'b0;
      beat("t7b0", 2, 16'h1111, 2'd0, 1'b0); cyc();
      beat("t7b1", 2, 16'h2222, 2'd1, 1'b0); cyc();
      beat("t7b2", 2, 16'h3333, 2'd2, 1'b0); cyc();
      beat("t7b3", 2, 16'h4444, 2'd3, 1'b1); cyc(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule

// File: doc/pixel_channel_serializer.md
Name: pixel_channel_serializer

Overview:
- Parametrised successor to the display adapter's fixed 3-channel buffer mux.
- Accepts one packed pixel of NCH colour channels, each W bits, through a valid/ready handshake.
- Emits the enabled channels one per beat on a W-bit output bus, also valid/ready, tagged with the channel index and a last-beat flag.
- Sits between the pixel source and the byte-wide display bus interface. Adds back-pressure, per-pixel channel masking, selectable order and a drop counter.

Parameters:
- W, 8: bits per colour channel.
- NCH, 3: channels per pixel. Channel k occupies pix_data[k*W +: W]; channel 0 = R, 1 = G, 2 = B.
- CH_ORDER, 0: 0 = ascending channel index first; 1 = descending.
- CW (derived, not overridable): max(1, clog2(NCH)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- pix_data  in  NCH*W  packed pixel.
- pix_valid  in  1  pixel offered.
- pix_ready  out  1  pixel can be accepted this cycle.
- chan_mask  in  NCH  bit k=1 sends channel k; sampled only at pixel acceptance.
- out_data  out  W  current channel value.
- out_chan  out  CW  index of the channel on out_data.
- out_last  out  1  final enabled channel of the current pixel.
- out_valid  out  1  beat offered.
- out_ready  in  1  downstream accepts beat.
- drop_cnt  out  16  count of pixels accepted with chan_mask all zero; saturating.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state changes occur on the rising clk edge.
- Reset values:
  - out_valid = 0, out_data = 0, out_chan = 0, out_last = 0, drop_cnt = 0.
  - FSM goes to IDLE.
  - pix_ready = 0 while rst = 1.
- FSM has two states, IDLE and SEND.
- pix_ready (combinational):
  - 1 in IDLE.
  - 1 in SEND only when out_valid & out_ready & out_last (last-beat handoff).
  - 0 otherwise.
- Accept = pix_valid & pix_ready.
  - On accept, pix_data and chan_mask are latched into internal registers.
- Accept with latched mask nonzero:
  - Next state is SEND.
  - Next cycle: out_valid = 1 carrying the first enabled channel in CH_ORDER. Latency from accept to first beat is 1 cycle.
- Accept with mask all zero:
  - No beats are produced; state is IDLE next cycle.
  - drop_cnt increments by 1 and holds at 0xFFFF.
- In SEND, out_data, out_chan and out_last hold stable while out_valid & ~out_ready.
- Beat handshake (out_valid & out_ready):
  - If more enabled channels remain, the next cycle presents the next enabled channel in CH_ORDER; disabled channels are skipped with no idle cycle.
  - out_last = 1 exactly on the final enabled channel. A single-bit mask gives one beat with out_last = 1.
- Last-beat handshake:
  - With a simultaneous accept: the new pixel's first beat appears the next cycle, giving zero bubble between pixels.
  - With a simultaneous accept of a zero-mask pixel: next state IDLE, out_valid = 0, drop_cnt increments.
  - Otherwise: next state IDLE, out_valid = 0.
- When out_valid = 0, out_data and out_chan retain the last transmitted value; they are not cleared except by reset.
- Changes to chan_mask or pix_data after accept do not affect the pixel in flight.
- rst asserted mid-pixel abandons remaining beats; all outputs take reset values at that edge. The first pixel after reset is accepted no earlier than the first cycle with rst = 0.
- Throughput: one beat per cycle under continuous out_ready. A full-mask pixel occupies NCH cycles.

Test Plan:
- Defaults; pix_data = 0x332211, mask = 3'b111, out_ready = 1.
  -> Beats (data, chan, last) = (0x11,0,0), (0x22,1,0), (0x33,2,1) on consecutive cycles.
  -> First beat 1 cycle after accept; pix_ready = 1 on the third beat.
- CH_ORDER = 1, mask = 3'b101, same pixel.
  -> Beats (0x33,2,0), (0x11,0,1); channel 1 skipped with no gap.
- out_ready held 0 for 4 cycles during beat 2.
  -> out_data stays 0x22, out_chan stays 1, out_valid stays 1, pix_ready = 0.
  -> Sequence resumes when out_ready = 1.
- Back-to-back pixels 0x332211 then 0x665544, pix_valid held high, out_ready = 1.
  -> Six beats 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 with out_valid continuously 1; out_last on 0x33 and 0x66.
- Mask = 0 for 3 pixels, then mask = 3'b010 for pixel 0x665544.
  -> drop_cnt = 3; single beat (0x55,1,1).
  -> When out_valid falls, out_data holds 0x55.
- rst pulsed for 1 cycle during beat 2 of a full-mask pixel.
  -> Next cycle: out_valid = 0, out_data = 0, drop_cnt = 0.
  -> The next pixel starts cleanly from its first enabled channel.
- NCH = 4, W = 16 build, mask = 4'b1111.
  -> Four 16-bit beats, out_chan 0..3, CW = 2.
